morse_keyer_tx: RTL

- Morse transmitter that runs on the fast system clock and generates the slow unit-time base internally by dividing the clock. This is the inverse of the slow-edge-to-fast-pulse path used on the receive side.
- Accepts one character per valid/ready handshake. The character is a dot/dash pattern plus length.
- Drives a registered KEY line with standard Morse timing: dot = 1 unit, dash = 3 units, element gap = 1, character gap = 3, word gap = 7.

---
 rtl/morse_pkg.sv | 20 ++
 rtl/morse_unit_timer.sv | 32 +++
 rtl/morse_keyer_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer transmitter.
// Unit counts are sized to the 3-bit unit counter in the keyer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_t;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  localparam int DEF_MAX_LEN = 6;

endpackage

// File: rtl/morse_unit_timer.sv
// Divides the fast clock into Morse units.
// TICK marks the last cycle of each unit while enabled.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic FAST,
  input  logic RESET_N,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int W = $clog2(UNIT_CYCLES);
  localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign TICK = EN && (cnt == LAST);

  always_ff @(posedge FAST) begin
    if (!RESET_N || CLR || !EN) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_keyer_tx.sv
// Morse keyer: one character per handshake, keyed with
// standard unit timing derived from the fast clock.
module morse_keyer_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000,
  parameter int MAX_LEN     = DEF_MAX_LEN
) (
  input  logic               FAST,
  input  logic               RESET_N,
  input  logic               CHAR_VALID,
  output logic               CHAR_READY,
  input  logic [2:0]         CHAR_LEN,
  input  logic [MAX_LEN-1:0] CHAR_BITS,
  input  logic               WORD_GAP,
  output logic               KEY,
  output logic               BUSY,
  output logic               UNIT_TICK
);

  state_t     state;
  logic [7:0] bits_q;
  logic [2:0] len_q;
  logic       wgap_q;
  logic [2:0] idx;
  logic [2:0] units;
  logic [2:0] next_idx;
  logic [2:0] len_c;
  logic       tick;
  logic       en;
  logic       take;

  assign en         = (state != IDLE);
  assign CHAR_READY = (state == IDLE);
  assign take       = CHAR_VALID && CHAR_READY;
  assign next_idx   = idx + 3'd1;
  assign UNIT_TICK  = tick;
  assign len_c      = (CHAR_LEN > 3'(MAX_LEN)) ? 3'(MAX_LEN)
                                               : CHAR_LEN;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .FAST   (FAST),
    .RESET_N(RESET_N),
    .EN     (en),
    .CLR    (take),
    .TICK   (tick)
  );

  always_ff @(posedge FAST) begin
    if (!RESET_N) begin
      state  <= IDLE;
      KEY    <= 1'b0;
      BUSY   <= 1'b0;
      bits_q <= '0;
      len_q  <= '0;
      wgap_q <= 1'b0;
      idx    <= '0;
      units  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CHAR_VALID) begin
            bits_q <= 8'(CHAR_BITS);
            len_q  <= len_c;
            wgap_q <= WORD_GAP;
            idx    <= '0;
            BUSY   <= 1'b1;
            // Zero length is a bare word space.
            if (len_c == 3'd0) begin
              state <= GAP;
              units <= WORD_GAP_UNITS;
            end else begin
              state <= MARK;
              KEY   <= 1'b1;
              units <= CHAR_BITS[0] ? DASH_UNITS : DOT_UNITS;
            end
          end
        end
        MARK: begin
          if (tick) begin
            if (units == 3'd1) begin
              KEY <= 1'b0;
              if (next_idx < len_q) begin
                state <= SPACE;
                units <= ELEM_GAP_UNITS;
              end else begin
                state <= GAP;
                units <= wgap_q ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
              end
            end else begin
              units <= units - 3'd1;
            end
          end
        end
        SPACE: begin
          if (tick) begin
            if (units == 3'd1) begin
              state <= MARK;
              KEY   <= 1'b1;
              idx   <= next_idx;
              units <= bits_q[next_idx] ? DASH_UNITS : DOT_UNITS;
            end else begin
              units <= units - 3'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (units == 3'd1) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              units <= units - 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
